// File: rtl/display_spi_sink.sv
// rtl/display_spi_sink.sv - SSD1306-side display SPI receiver with command decode and framebuffer write port
// Optional frame_done output enabled by DISPLAY_SPI_SINK_FRAME_DONE_EN.
module display_spi_sink #(
  parameter int SYNC_STAGES = 2,
  parameter int COLS        = 128,
  parameter int PAGES       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_din,
  input  logic       spi_clk,
  input  logic       spi_cs,
  input  logic       spi_dc,
  input  logic       spi_rst,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_dc,
  output logic       fb_we,
  output logic [9:0] fb_addr,
  output logic [7:0] fb_data,
  output logic       display_on,
  output logic       cmd_error
`ifdef DISPLAY_SPI_SINK_FRAME_DONE_EN
  , output logic     frame_done
`endif
);
  localparam int CW = $clog2(COLS);
  localparam int PW = $clog2(PAGES);
  // Synchronizer bit order {din, clk, cs, dc, rst}; cs and rst idle high.
  localparam logic [4:0] SYNC_RST = 5'b00101;

  typedef enum logic {IDLE, ARG} state_t;
  typedef enum logic [1:0] {K_SKIP, K_COL, K_PAGE} kind_t;

  logic [4:0]    sync_q [SYNC_STAGES];
  logic          s_din, s_clk, s_cs, s_dc, s_rst;
  logic          clk_prev, sample, byte_done;
  logic [6:0]    shreg;
  logic [2:0]    bit_cnt;
  logic [7:0]    byte_in;
  state_t        state, state_d;
  kind_t         kind, kind_d;
  logic [1:0]    left, left_d;
  logic [6:0]    arg0, arg0_d;
  logic [CW-1:0] col, col_d, col_start, col_start_d, col_end, col_end_d;
  logic [PW-1:0] page, page_d, page_start, page_start_d, page_end, page_end_d;
  logic          disp_d, wr, err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
    end else begin
      sync_q[0] <= {spi_din, spi_clk, spi_cs, spi_dc, spi_rst};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign {s_din, s_clk, s_cs, s_dc, s_rst} = sync_q[SYNC_STAGES-1];
  assign sample    = s_clk && !clk_prev && !s_cs && s_rst;
  assign byte_done = sample && (bit_cnt == 3'd7);
  assign byte_in   = {shreg, s_din};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      state <= IDLE;
    else if (!s_rst) state <= IDLE;
    else             state <= state_d;
  end

  always_comb begin
    state_d      = state;
    kind_d       = kind;
    left_d       = left;
    arg0_d       = arg0;
    col_d        = col;
    col_start_d  = col_start;
    col_end_d    = col_end;
    page_d       = page;
    page_start_d = page_start;
    page_end_d   = page_end;
    disp_d       = display_on;
    wr           = 1'b0;
    err          = 1'b0;
    if (byte_done) begin
      if (s_dc) begin
        // Data aborts a pending command; the window stays as it was.
        if (state == ARG) begin
          err     = 1'b1;
          state_d = IDLE;
        end
        wr = 1'b1;
        if (col == col_end) begin
          col_d  = col_start;
          page_d = (page == page_end) ? page_start : page + 1'b1;
        end else begin
          col_d = col + 1'b1;
        end
      end else if (state == IDLE) begin
        case (byte_in)
          8'h21: begin state_d = ARG; kind_d = K_COL;  left_d = 2'd2; end
          8'h22: begin state_d = ARG; kind_d = K_PAGE; left_d = 2'd2; end
          8'h81, 8'hD5, 8'hA8, 8'hD3, 8'h8D, 8'h20, 8'hDA, 8'hD9, 8'hDB:
                 begin state_d = ARG; kind_d = K_SKIP; left_d = 2'd1; end
          8'hAE: disp_d = 1'b0;
          8'hAF: disp_d = 1'b1;
          default: ;
        endcase
      end else begin
        left_d = left - 2'd1;
        if (left == 2'd2) begin
          arg0_d = byte_in[6:0];
        end else begin
          // Window is committed only once both arguments are in.
          state_d = IDLE;
          case (kind)
            K_COL: begin
              col_start_d = arg0[CW-1:0];
              col_end_d   = byte_in[CW-1:0];
              col_d       = arg0[CW-1:0];
            end
            K_PAGE: begin
              page_start_d = arg0[PW-1:0];
              page_end_d   = byte_in[PW-1:0];
              page_d       = arg0[PW-1:0];
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_prev   <= 1'b0;
      cmd_error  <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      rx_valid   <= 1'b0;
      rx_byte    <= '0;
      rx_dc      <= 1'b0;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= '0;
      display_on <= 1'b0;
      kind       <= K_SKIP;
      left       <= '0;
      arg0       <= '0;
      col        <= '0;
      col_start  <= '0;
      col_end    <= CW'(COLS - 1);
      page       <= '0;
      page_start <= '0;
      page_end   <= PW'(PAGES - 1);
`ifdef DISPLAY_SPI_SINK_FRAME_DONE_EN
      frame_done <= 1'b0;
`endif
    end else begin
      clk_prev <= s_clk;
      if (err) cmd_error <= 1'b1;
      if (!s_rst) begin
        shreg      <= '0;
        bit_cnt    <= '0;
        rx_valid   <= 1'b0;
        rx_byte    <= '0;
        rx_dc      <= 1'b0;
        fb_we      <= 1'b0;
        fb_addr    <= '0;
        fb_data    <= '0;
        display_on <= 1'b0;
        kind       <= K_SKIP;
        left       <= '0;
        arg0       <= '0;
        col        <= '0;
        col_start  <= '0;
        col_end    <= CW'(COLS - 1);
        page       <= '0;
        page_start <= '0;
        page_end   <= PW'(PAGES - 1);
`ifdef DISPLAY_SPI_SINK_FRAME_DONE_EN
        frame_done <= 1'b0;
`endif
      end else begin
        rx_valid <= byte_done;
        fb_we    <= wr;
`ifdef DISPLAY_SPI_SINK_FRAME_DONE_EN
        frame_done <= wr && (col == col_end) && (page == page_end);
`endif
        if (sample) begin
          shreg   <= byte_in[6:0];
          bit_cnt <= bit_cnt + 3'd1;
        end else if (s_cs) begin
          bit_cnt <= '0;
        end
        if (byte_done) begin
          rx_byte <= byte_in;
          rx_dc   <= s_dc;
        end
        if (wr) begin
          fb_addr <= {page, col};
          fb_data <= byte_in;
        end
        display_on <= disp_d;
        kind       <= kind_d;
        left       <= left_d;
        arg0       <= arg0_d;
        col        <= col_d;
        col_start  <= col_start_d;
        col_end    <= col_end_d;
        page       <= page_d;
        page_start <= page_start_d;
        page_end   <= page_end_d;
      end
    end
  end
endmodule

// File: tb/tb_display_spi_sink.sv
// tb/tb_display_spi_sink.sv - directed self-checking bench for display_spi_sink
module tb_display_spi_sink;
  logic       clk = 1'b0;
  logic       rst_n, spi_din, spi_clk, spi_cs, spi_dc, spi_rst;
  logic       rx_valid, rx_dc, fb_we, display_on, cmd_error;
  logic [7:0] rx_byte, fb_data;
  logic [9:0] fb_addr;
`ifdef DISPLAY_SPI_SINK_FRAME_DONE_EN
  logic       frame_done;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] rxq[$];
  logic       rxdcq[$];
  logic [9:0] addrq[$];
  logic [7:0] dataq[$];
  logic       fdq[$];

  display_spi_sink dut (
    .clk(clk), .rst_n(rst_n), .spi_din(spi_din), .spi_clk(spi_clk),
    .spi_cs(spi_cs), .spi_dc(spi_dc), .spi_rst(spi_rst),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_dc(rx_dc),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .display_on(display_on), .cmd_error(cmd_error)
`ifdef DISPLAY_SPI_SINK_FRAME_DONE_EN
    , .frame_done(frame_done)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      rxq.push_back(rx_byte);
      rxdcq.push_back(rx_dc);
    end
    if (fb_we) begin
      addrq.push_back(fb_addr);
      dataq.push_back(fb_data);
`ifdef DISPLAY_SPI_SINK_FRAME_DONE_EN
      fdq.push_back(frame_done);
`else
      fdq.push_back(1'b0);
`endif
    end
    if (rx_valid && !rx_dc && fb_we) begin
      errors++;
      $display("FAIL fb_we_on_cmd observed 1 expected 0");
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_q();
    rxq.delete(); rxdcq.delete(); addrq.delete(); dataq.delete(); fdq.delete();
  endtask

  // spi_clk = clk/22: 11 system clocks per half period.
  task automatic send_bits(input logic [7:0] b, input int n, input logic dc);
    spi_cs = 1'b0;
    spi_dc = dc;
    for (int i = 7; i > 7 - n; i--) begin
      spi_din = b[i];
      clks(11);
      spi_clk = 1'b1;
      clks(11);
      spi_clk = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    send_bits(b, 8, dc);
  endtask

  task automatic end_frame();
    clks(11);
    spi_cs = 1'b1;
    clks(11);
  endtask

  initial begin
    rst_n = 1'b0; spi_din = 1'b0; spi_clk = 1'b0;
    spi_cs = 1'b1; spi_dc = 1'b0; spi_rst = 1'b1;
    clks(5);
    chk("reset_outputs", 32'({rx_valid, rx_byte, rx_dc, fb_we, fb_addr, fb_data, display_on, cmd_error}), 32'h0);
    rst_n = 1'b1;
    clks(5);

    // Display on command
    clear_q();
    send_byte(8'hAF, 1'b0);
    end_frame();
    chk("af_rx_count", 32'(rxq.size()), 32'd1);
    chk("af_rx_byte", 32'(rxq[0]), 32'hAF);
    chk("af_rx_dc", 32'(rxdcq[0]), 32'd0);
    chk("af_display_on", 32'(display_on), 32'd1);
    chk("af_no_fb_we", 32'(addrq.size()), 32'd0);

    // Full window, two data bytes
    clear_q();
    send_byte(8'h21, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h7F, 1'b0);
    send_byte(8'h22, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h07, 1'b0);
    send_byte(8'h55, 1'b1); send_byte(8'hAA, 1'b1);
    end_frame();
    chk("win_rx_count", 32'(rxq.size()), 32'd8);
    chk("win_wr_count", 32'(addrq.size()), 32'd2);
    chk("win_addr0", 32'(addrq[0]), 32'h000);
    chk("win_addr1", 32'(addrq[1]), 32'h001);
    chk("win_data0", 32'(dataq[0]), 32'h55);
    chk("win_data1", 32'(dataq[1]), 32'hAA);
    chk("win_last_dc", 32'(rxdcq[7]), 32'd1);

    // Small window wrap: cols 0x10..0x11, pages 2..3
    clear_q();
    send_byte(8'h21, 1'b0); send_byte(8'h10, 1'b0); send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0);
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    end_frame();
    chk("wrap_wr_count", 32'(addrq.size()), 32'd5);
    chk("wrap_addr0", 32'(addrq[0]), 32'h110);
    chk("wrap_addr1", 32'(addrq[1]), 32'h111);
    chk("wrap_addr2", 32'(addrq[2]), 32'h190);
    chk("wrap_addr3", 32'(addrq[3]), 32'h191);
    chk("wrap_addr4", 32'(addrq[4]), 32'h110);
    chk("wrap_data4", 32'(dataq[4]), 32'h05);
`ifdef DISPLAY_SPI_SINK_FRAME_DONE_EN
    chk("wrap_frame_done", 32'({fdq[0], fdq[1], fdq[2], fdq[3], fdq[4]}), 32'b00010);
`endif

    // Aborted partial byte
    clear_q();
    send_bits(8'hFF, 5, 1'b0);
    end_frame();
    send_byte(8'h3C, 1'b0);
    end_frame();
    chk("abort_rx_count", 32'(rxq.size()), 32'd1);
    chk("abort_rx_byte", 32'(rxq[0]), 32'h3C);

    // Bus reset clears pending command and window, not cmd_error
    clear_q();
    send_byte(8'h21, 1'b0); send_byte(8'h05, 1'b0);
    end_frame();
    spi_rst = 1'b0;
    clks(20);
    spi_rst = 1'b1;
    clks(5);
    send_byte(8'h01, 1'b1);
    end_frame();
    chk("busrst_addr", 32'(addrq[0]), 32'h000);
    chk("busrst_cmd_error", 32'(cmd_error), 32'd0);

    // Same sequence without the reset pulse
    clear_q();
    send_byte(8'h21, 1'b0); send_byte(8'h05, 1'b0); send_byte(8'h01, 1'b1);
    end_frame();
    chk("abortcmd_cmd_error", 32'(cmd_error), 32'd1);
    chk("abortcmd_addr", 32'(addrq[0]), 32'h001);

    // Async reset mid-byte with spi_clk toggling
    send_byte(8'hAF, 1'b0);
    end_frame();
    send_bits(8'hFF, 4, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", 32'({rx_valid, rx_byte, rx_dc, fb_we, fb_addr, fb_data, display_on, cmd_error}), 32'h0);
    clks(11); spi_clk = 1'b1; clks(11); spi_clk = 1'b0;
    rst_n = 1'b1;
    spi_cs = 1'b1;
    clks(11);
    clear_q();
    send_byte(8'hA5, 1'b0);
    end_frame();
    chk("post_rst_rx_count", 32'(rxq.size()), 32'd1);
    chk("post_rst_rx_byte", 32'(rxq[0]), 32'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/display_spi_sink.md
Name: display_spi_sink

Overview:
- SSD1306-side receiver for the 4-wire display SPI bus (din, clk, cs, dc, rst) driven by the display SPI master.
- Oversamples the bus in the system clock, assembles bytes and classifies each as command or data.
- Tracks the controller's column/page window and writes each data byte to a framebuffer write port.
- Used as a display emulator in simulation and as an on-FPGA loopback/checker for the display driver.

Parameters:
- SYNC_STAGES, 2, synchronizer flops per SPI input (minimum 2).
- COLS, 128, display columns; column counter is 7 bits.
- PAGES, 8, display pages; page counter is 3 bits.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- spi_din  in  1  serial data, MSB first; changes on falling spi_clk
- spi_clk  in  1  serial clock; idles low; must be at most clk/8
- spi_cs  in  1  chip select, active low
- spi_dc  in  1  0 = command, 1 = data
- spi_rst  in  1  display hardware reset, active low
- rx_valid  out  1  one-cycle pulse when a byte completes
- rx_byte  out  8  completed byte; held until the next rx_valid
- rx_dc  out  1  dc sampled with the byte's 8th bit
- fb_we  out  1  one-cycle framebuffer write strobe
- fb_addr  out  10  page*128 + column
- fb_data  out  8  data byte; bit0 is the top row of the page
- display_on  out  1  1 after 0xAF, 0 after 0xAE
- cmd_error  out  1  sticky; set by a data byte received while command arguments are pending

Behaviour:
- Reset: async on rst_n low. All outputs are 0. Synchronizer flops are 1 for cs and rst, 0 for the others. Window is col 0..127, page 0..7, with col = page = 0. bit_cnt = 0. Decoder is in IDLE.
- Input path: all five inputs pass through SYNC_STAGES flops. A sampling event is a rising edge of synchronized spi_clk while synchronized cs = 0. On that event, shift in din (MSB first) and increment bit_cnt.
- Byte completion: on the 8th bit, rx_valid pulses exactly 1 clk later. At the same time rx_byte and rx_dc are updated and bit_cnt returns to 0.
- CS framing: synchronized cs = 1 clears bit_cnt and discards any partial byte. Multiple bytes may arrive under one cs-low period.
- Bus reset: synchronized spi_rst = 0 acts like rst_n except on the synchronizers and on cmd_error. While spi_rst is low, no bytes are accepted. Releasing it mid-byte restarts cleanly.
- Decoder FSM, IDLE state: a command byte is classified as follows.
  - 0x21 (COLUMNADDR): go to ARG, expecting 2 arguments.
  - 0x22 (PAGEADDR): go to ARG, expecting 2 arguments.
  - 0x81, 0xD5, 0xA8, 0xD3, 0x8D, 0x20, 0xDA, 0xD9, 0xDB: go to ARG, expecting 1 argument (consumed and ignored).
  - 0xAE: display_on = 0. 0xAF: display_on = 1.
  - Any other command: ignored.
- Decoder FSM, ARG state:
  - Each command byte is consumed as an argument.
  - COLUMNADDR arguments set col_start and col_end (bit 7 masked), then col = col_start.
  - PAGEADDR arguments set page_start and page_end (bits 2:0), then page = page_start.
  - After the last argument, return to IDLE.
- Data in ARG state: set cmd_error, abort the command (window unchanged), return to IDLE, then process the byte as data.
- Data byte: fb_we pulses in the same cycle as rx_valid, with fb_addr = {page, col} before advancing. Advance is horizontal mode only:
  - if col == col_end: col = col_start, and page = (page == page_end) ? page_start : page+1;
  - otherwise col = col+1.
- Degenerate window: if end < start, only the equality test wraps. The counter runs up through 127 (or 7), rolls over to 0, and wraps when it reaches the end value.
- fb_we is never asserted on command bytes.

Optional Feature:
- Macro: DISPLAY_SPI_SINK_FRAME_DONE_EN.
- When defined: adds output frame_done (1 bit). It pulses together with fb_we for the write at (page_end, col_end), i.e. the write that wraps to (page_start, col_start).
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then bus traffic. Command 0xAF, spi_clk = clk/22 → rx_valid ×1, rx_byte = 0xAF, rx_dc = 0, display_on = 1, fb_we never asserted.
- Address window. Commands 21 00 7F 22 00 07, then data 0x55, 0xAA → fb_addr 0 then 1, fb_data 0x55 then 0xAA.
- Column wrap. Commands 21 10 11 22 02 03, then 5 data bytes → fb_addr 0x110, 0x111, 0x190, 0x191, 0x110. With frame_done enabled, it pulses on the 4th write only.
- Aborted frame. cs raised after 5 bits, then a full byte 0x3C is sent → single rx_valid with rx_byte = 0x3C.
- Bus reset mid-traffic. Command 0x21 with one argument, spi_rst pulsed low, then data 0x01 → fb_addr 0 and cmd_error stays 0. In the same sequence without the spi_rst pulse, cmd_error = 1.
- Async reset with spi_clk toggling. rst_n asserted mid-byte → all outputs 0 immediately, and the first full byte after release is decoded correctly.
